// File: rtl/icache_nway_pkg.sv
// -----------------------------------------------------------------------------
// icache_nway_pkg
// Shared definitions for the N-way instruction cache:
//   - state_e    : refill controller states (IDLE, FILL, FILLEND)
//   - WORD_LSB   : byte-offset bits below the 32-bit word index
//   - addr_field : extracts a bit field from an address, used to split a fetch
//                  address into word index, set index and tag
// Optional feature macro used by the cache top: ICACHE_NWAY_STATS_EN
// -----------------------------------------------------------------------------
package icache_nway_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_FILLEND = 2'd2
   } state_e;

   localparam int unsigned WORD_LSB = 2;

   // Returns addr[lsb +: width] zero-extended to 64 bits.
   function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                              input int unsigned lsb,
                                              input int unsigned width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/icache_nway_if.sv
// -----------------------------------------------------------------------------
// icache_nway_if
// Bundles the CPU fetch port and the code-memory refill port of icache_nway.
//   fetch / fetch_addr / invalidate      : CPU -> cache request side
//   inst_ready / inst_data / busy        : cache -> CPU response side
//   code_rd / code_addr                  : cache -> code memory burst request
//   code_valid / code_data               : code memory -> cache refill data
// Modports:
//   slave  : the cache's view
//   master : the environment's view (CPU plus code memory)
// -----------------------------------------------------------------------------
interface icache_nway_if #(
   parameter int ADDRLEN = 24
);
   logic                 fetch;
   logic [ADDRLEN-1:0]   fetch_addr;
   logic                 invalidate;
   logic                 inst_ready;
   logic [31:0]          inst_data;
   logic                 code_rd;
   logic [ADDRLEN-3:0]   code_addr;
   logic                 code_valid;
   logic [31:0]          code_data;
   logic                 busy;

   modport slave (
      input  fetch, fetch_addr, invalidate, code_valid, code_data,
      output inst_ready, inst_data, code_rd, code_addr, busy
   );

   modport master (
      output fetch, fetch_addr, invalidate, code_valid, code_data,
      input  inst_ready, inst_data, code_rd, code_addr, busy
   );
endinterface

// File: rtl/icache_nway_lru.sv
// -----------------------------------------------------------------------------
// icache_lru
// True-LRU age tracking for every set of the cache. Each way of a set holds an
// age; ages of a set always form a permutation of 0..WAYS-1 (0 = most recent).
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset (way w resets to age w)
//   set_i      : set whose ages are used for victim select and update
//   valid_i    : valid bits of set_i (already masked by a same-cycle invalidate)
//   upd_en_i   : touch upd_way_i in set_i this cycle (hit or fill)
//   upd_way_i  : way being touched
//   victim_o   : lowest invalid way, else the way whose age is WAYS-1
// -----------------------------------------------------------------------------
module icache_lru #(
   parameter int WAYS_LOG2 = 2,
   parameter int SETS_LOG2 = 6
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [SETS_LOG2-1:0]        set_i,
   input  logic [(1<<WAYS_LOG2)-1:0]   valid_i,
   input  logic                        upd_en_i,
   input  logic [WAYS_LOG2-1:0]        upd_way_i,
   output logic [WAYS_LOG2-1:0]        victim_o
);
   localparam int WAYS = 1 << WAYS_LOG2;
   localparam int SETS = 1 << SETS_LOG2;

   logic [WAYS_LOG2-1:0] age_q [SETS][WAYS];
   logic [WAYS_LOG2-1:0] old_age_s;
   logic [WAYS_LOG2-1:0] inv_way_s;
   logic [WAYS_LOG2-1:0] old_way_s;
   logic                 any_inv_s;

   // Victim select and the age of the way being touched.
   always_comb begin
      old_age_s = age_q[set_i][upd_way_i];
      inv_way_s = '0;
      old_way_s = '0;
      any_inv_s = 1'b0;
      // Scan downwards so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         inv_way_s = valid_i[w] ? inv_way_s : WAYS_LOG2'(w);
         any_inv_s = any_inv_s | ~valid_i[w];
         old_way_s = (age_q[set_i][w] == WAYS_LOG2'(WAYS - 1)) ? WAYS_LOG2'(w) : old_way_s;
      end
      victim_o = any_inv_s ? inv_way_s : old_way_s;
   end

   // Age update: touched way becomes 0, every younger way ages by one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               age_q[s][w] <= WAYS_LOG2'(w);
            end
         end
      end else if (upd_en_i) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAYS_LOG2'(w) == upd_way_i) begin
               age_q[set_i][w] <= '0;
            end else if (age_q[set_i][w] < old_age_s) begin
               age_q[set_i][w] <= age_q[set_i][w] + WAYS_LOG2'(1);
            end
         end
      end
   end

endmodule

// File: rtl/icache_nway.sv
// -----------------------------------------------------------------------------
// icache_nway
// Read-only set-associative instruction cache between a CPU fetch port and a
// code memory. Tags and valid bits are flops; line data lives in a
// synchronous-read array whose read register is also the inst_data register.
// Misses refill critical-word-first with a wrapping burst and restart the CPU
// as soon as the requested word arrives.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : icache_nway_if.slave (fetch, refill and status signals)
//   stats_clr_i, hit_cnt_o, miss_cnt_o : only with ICACHE_NWAY_STATS_EN
// Parameters: ADDRLEN, WAYS_LOG2 (1..3), SETS_LOG2, LINE_LOG2 (>= 1).
// Optional feature macro: ICACHE_NWAY_STATS_EN (saturating hit/miss counters).
// -----------------------------------------------------------------------------
module icache_nway
   import icache_nway_pkg::*;
#(
   parameter int ADDRLEN   = 24,
   parameter int WAYS_LOG2 = 2,
   parameter int SETS_LOG2 = 6,
   parameter int LINE_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rstn,
   icache_nway_if.slave bus
`ifdef ICACHE_NWAY_STATS_EN
   ,
   input  logic        stats_clr_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
`endif
);
   localparam int WAYS       = 1 << WAYS_LOG2;
   localparam int SETS       = 1 << SETS_LOG2;
   localparam int LINE_WORDS = 1 << LINE_LOG2;
   localparam int TAGW       = ADDRLEN - 2 - LINE_LOG2 - SETS_LOG2;
   localparam int MEMW       = WAYS_LOG2 + SETS_LOG2 + LINE_LOG2;
   localparam int MEM_DEPTH  = 1 << MEMW;

   // Storage
   logic [31:0]          mem_q   [MEM_DEPTH];
   logic [TAGW-1:0]      tag_q   [WAYS][SETS];
   logic [WAYS-1:0]      valid_q [SETS];

   // Controller registers
   state_e               state_q;
   logic                 inst_ready_q;
   logic [31:0]          inst_data_q;
   logic                 code_rd_q;
   logic [ADDRLEN-3:0]   code_addr_q;
   logic                 busy_q;
   logic [WAYS_LOG2-1:0] victim_q;
   logic [LINE_LOG2-1:0] cnt_q;
   logic                 inval_seen_q;

   // Lookup path
   logic [63:0]          fa64_s;
   logic [LINE_LOG2-1:0] lk_word_s;
   logic [SETS_LOG2-1:0] lk_set_s;
   logic [TAGW-1:0]      lk_tag_s;
   logic [WAYS-1:0]      eff_valid_s;
   logic                 hit_s;
   logic [WAYS_LOG2-1:0] hit_way_s;
   logic                 lookup_s;
   logic                 hit_go_s;
   logic                 miss_go_s;
   logic [MEMW-1:0]      rd_idx_s;

   // Refill path: tag and set are constant in code_addr_q during a burst,
   // only the word field advances.
   logic [SETS_LOG2-1:0] fill_set_s;
   logic [TAGW-1:0]      fill_tag_s;
   logic [MEMW-1:0]      fill_idx_s;
   logic                 fill_wr_s;
   logic                 fill_end_s;

   // LRU interface
   logic [SETS_LOG2-1:0] lru_set_s;
   logic                 lru_upd_s;
   logic [WAYS_LOG2-1:0] lru_way_s;
   logic [WAYS_LOG2-1:0] victim_s;

   assign fa64_s    = 64'(bus.fetch_addr);
   assign lk_word_s = LINE_LOG2'(addr_field(fa64_s, WORD_LSB, LINE_LOG2));
   assign lk_set_s  = SETS_LOG2'(addr_field(fa64_s, WORD_LSB + LINE_LOG2, SETS_LOG2));
   assign lk_tag_s  = TAGW'(addr_field(fa64_s, WORD_LSB + LINE_LOG2 + SETS_LOG2, TAGW));

   // A same-cycle invalidate already hides every line from this lookup.
   assign eff_valid_s = bus.invalidate ? '0 : valid_q[lk_set_s];

   // Tag compare across all ways of the addressed set.
   always_comb begin
      hit_s     = 1'b0;
      hit_way_s = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_s     = hit_s | (eff_valid_s[w] & (tag_q[w][lk_set_s] == lk_tag_s));
         hit_way_s = (eff_valid_s[w] && (tag_q[w][lk_set_s] == lk_tag_s)) ? WAYS_LOG2'(w) : hit_way_s;
      end
   end

   assign lookup_s  = (state_q == ST_IDLE) & bus.fetch;
   assign hit_go_s  = lookup_s & hit_s;
   assign miss_go_s = lookup_s & ~hit_s;
   assign rd_idx_s  = {hit_way_s, lk_set_s, lk_word_s};

   assign fill_set_s = code_addr_q[LINE_LOG2 +: SETS_LOG2];
   assign fill_tag_s = code_addr_q[ADDRLEN-3 -: TAGW];
   assign fill_idx_s = {victim_q, fill_set_s, code_addr_q[LINE_LOG2-1:0]};
   assign fill_wr_s  = (state_q == ST_FILL) & bus.code_valid;
   assign fill_end_s = (state_q == ST_FILLEND);

   assign lru_set_s = fill_end_s ? fill_set_s : lk_set_s;
   assign lru_upd_s = hit_go_s | fill_end_s;
   assign lru_way_s = fill_end_s ? victim_q : hit_way_s;

   icache_lru #(
      .WAYS_LOG2 (WAYS_LOG2),
      .SETS_LOG2 (SETS_LOG2)
   ) u_lru (
      .clk       (clk),
      .rstn      (rstn),
      .set_i     (lru_set_s),
      .valid_i   (eff_valid_s),
      .upd_en_i  (lru_upd_s),
      .upd_way_i (lru_way_s),
      .victim_o  (victim_s)
   );

   // Controller FSM with registered CPU/refill outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         inst_ready_q <= 1'b0;
         inst_data_q  <= 32'd0;
         code_rd_q    <= 1'b0;
         code_addr_q  <= '0;
         busy_q       <= 1'b0;
         victim_q     <= '0;
         cnt_q        <= '0;
         inval_seen_q <= 1'b0;
      end else begin
         inst_ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (hit_go_s) begin
                  inst_ready_q <= 1'b1;
                  inst_data_q  <= mem_q[rd_idx_s];
               end else if (miss_go_s) begin
                  state_q      <= ST_FILL;
                  busy_q       <= 1'b1;
                  code_rd_q    <= 1'b1;
                  code_addr_q  <= {lk_tag_s, lk_set_s, lk_word_s};
                  victim_q     <= victim_s;
                  cnt_q        <= '0;
                  inval_seen_q <= 1'b0;
               end
            end
            ST_FILL: begin
               if (bus.invalidate) begin
                  inval_seen_q <= 1'b1;
               end
               if (bus.code_valid) begin
                  code_addr_q[LINE_LOG2-1:0] <= code_addr_q[LINE_LOG2-1:0] + LINE_LOG2'(1);
                  cnt_q <= cnt_q + LINE_LOG2'(1);
                  // Early restart: first beat is the requested word.
                  if ((cnt_q == '0) && bus.fetch) begin
                     inst_ready_q <= 1'b1;
                     inst_data_q  <= bus.code_data;
                  end
                  if (cnt_q == LINE_LOG2'(LINE_WORDS - 1)) begin
                     code_rd_q <= 1'b0;
                     state_q   <= ST_FILLEND;
                  end
               end
            end
            ST_FILLEND: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= ST_IDLE;
               busy_q    <= 1'b0;
               code_rd_q <= 1'b0;
            end
         endcase
      end
   end

   // Valid bits: invalidate wins over the end-of-fill set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else if (bus.invalidate) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else if (fill_end_s && !inval_seen_q) begin
         valid_q[fill_set_s][victim_q] <= 1'b1;
      end
   end

   // Tag write at the end of a refill.
   always_ff @(posedge clk) begin
      if (fill_end_s) begin
         tag_q[victim_q][fill_set_s] <= fill_tag_s;
      end
   end

   // Line data write, one word per refill beat.
   always_ff @(posedge clk) begin
      if (fill_wr_s) begin
         mem_q[fill_idx_s] <= bus.code_data;
      end
   end

   assign bus.inst_ready = inst_ready_q;
   assign bus.inst_data  = inst_data_q;
   assign bus.code_rd    = code_rd_q;
   assign bus.code_addr  = code_addr_q;
   assign bus.busy       = busy_q;

`ifdef ICACHE_NWAY_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   // Saturating counters; clear has priority over counting.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (stats_clr_i) begin
         hit_cnt_d  = 32'd0;
         miss_cnt_d = 32'd0;
      end else begin
         hit_cnt_d  = (hit_go_s && (hit_cnt_q != 32'hFFFF_FFFF)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
         miss_cnt_d = (miss_go_s && (miss_cnt_q != 32'hFFFF_FFFF)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_nway.sv
// -----------------------------------------------------------------------------
// tb_icache_nway
// Directed bench for icache_nway (24-bit address, 4 ways, 64 sets, 8-word
// lines). Code memory returns 32'hA500_0000 | word_address for every word, so
// every expected instruction is known from the address alone.
// -----------------------------------------------------------------------------
module tb_icache_nway;
   logic clk;
   logic rstn;
   int   checks;
   int   errs;

   icache_nway_if #(.ADDRLEN(24)) bus ();

`ifdef ICACHE_NWAY_STATS_EN
   logic        stats_clr;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   icache_nway #(
      .ADDRLEN   (24),
      .WAYS_LOG2 (2),
      .SETS_LOG2 (6),
      .LINE_LOG2 (3)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
`ifdef ICACHE_NWAY_STATS_EN
      ,
      .stats_clr_i (stats_clr),
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serves a wrapping 8-word burst starting at first_w; optionally pulses
   // invalidate on beat inval_k. Expects early restart on the first beat.
   task automatic fill_line(input logic [21:0] first_w, input string tag, input int inval_k);
      logic [21:0] w;
      logic [2:0]  lo;
      for (int k = 0; k < 8; k++) begin
         lo = first_w[2:0] + 3'(k);
         w  = {first_w[21:3], lo};
         chk({tag, "/code_addr"}, 64'(bus.code_addr), 64'(w));
         bus.code_valid = 1'b1;
         bus.code_data  = 32'hA500_0000 | 32'(w);
         bus.invalidate = (k == inval_k);
         step();
         bus.invalidate = 1'b0;
         if (k == 0) begin
            chk({tag, "/restart_ready"}, 64'(bus.inst_ready), 64'd1);
            chk({tag, "/restart_data"}, 64'(bus.inst_data), 64'(32'hA500_0000 | 32'(first_w)));
            bus.fetch = 1'b0;
         end
      end
      bus.code_valid = 1'b0;
      chk({tag, "/fillend_code_rd"}, 64'(bus.code_rd), 64'd0);
      chk({tag, "/fillend_busy"}, 64'(bus.busy), 64'd1);
      step();
      chk({tag, "/idle_busy"}, 64'(bus.busy), 64'd0);
   endtask

   // One fetch: expect either a hit (data next cycle) or a miss plus refill.
   task automatic access(input logic [23:0] a, input bit exp_miss, input string tag);
      bus.fetch      = 1'b1;
      bus.fetch_addr = a;
      step();
      chk({tag, "/miss"}, 64'(bus.code_rd), 64'(exp_miss));
      chk({tag, "/ready"}, 64'(bus.inst_ready), 64'(!exp_miss));
      if (exp_miss) begin
         fill_line(a[23:2], tag, -1);
      end else begin
         chk({tag, "/data"}, 64'(bus.inst_data), 64'(32'hA500_0000 | 32'(a[23:2])));
         bus.fetch = 1'b0;
         step();
      end
   endtask

   initial begin
      checks = 0;
      errs   = 0;
      rstn   = 1'b0;
      bus.fetch      = 1'b0;
      bus.fetch_addr = 24'h0;
      bus.invalidate = 1'b0;
      bus.code_valid = 1'b0;
      bus.code_data  = 32'h0;
`ifdef ICACHE_NWAY_STATS_EN
      stats_clr = 1'b0;
`endif
      step();
      step();
      chk("rst/inst_ready", 64'(bus.inst_ready), 64'd0);
      chk("rst/inst_data", 64'(bus.inst_data), 64'd0);
      chk("rst/code_rd", 64'(bus.code_rd), 64'd0);
      chk("rst/code_addr", 64'(bus.code_addr), 64'd0);
      chk("rst/busy", 64'(bus.busy), 64'd0);
      rstn = 1'b1;
      step();

      // Cold miss at 0x104: burst 0x41..0x47, 0x40.
      bus.fetch      = 1'b1;
      bus.fetch_addr = 24'h000104;
      step();
      chk("cold/code_rd", 64'(bus.code_rd), 64'd1);
      chk("cold/busy", 64'(bus.busy), 64'd1);
      chk("cold/ready_low", 64'(bus.inst_ready), 64'd0);
      fill_line(22'h41, "cold", -1);

      // Back-to-back hits over the whole line, one word per cycle.
      bus.fetch      = 1'b1;
      bus.fetch_addr = 24'h000100;
      step();
      for (int i = 0; i < 8; i++) begin
         chk("pipe/ready", 64'(bus.inst_ready), 64'd1);
         chk("pipe/data", 64'(bus.inst_data), 64'(32'hA500_0040 + 32'(i)));
         chk("pipe/code_rd", 64'(bus.code_rd), 64'd0);
         if (i < 7) begin
            bus.fetch_addr = 24'h000100 + 24'(4 * (i + 1));
         end else begin
            bus.fetch = 1'b0;
         end
         step();
      end
      chk("pipe/ready_end", 64'(bus.inst_ready), 64'd0);

      // Set 3: five tags; first is evicted, second becomes the next victim.
      access(24'h000060, 1'b1, "lru1/A0");
      access(24'h000860, 1'b1, "lru1/A1");
      access(24'h001060, 1'b1, "lru1/A2");
      access(24'h001860, 1'b1, "lru1/A3");
      access(24'h002060, 1'b1, "lru1/A4");
      access(24'h000060, 1'b1, "lru1/A0_again");
      access(24'h001060, 1'b0, "lru1/A2_hit");
      access(24'h001860, 1'b0, "lru1/A3_hit");
      access(24'h002060, 1'b0, "lru1/A4_hit");
      access(24'h000860, 1'b1, "lru1/A1_evicted");

      // Set 4: A,B,A hits then a new tag evicts the oldest remaining way.
      access(24'h000080, 1'b1, "lru2/B0");
      access(24'h000880, 1'b1, "lru2/B1");
      access(24'h001080, 1'b1, "lru2/B2");
      access(24'h001880, 1'b1, "lru2/B3");
      access(24'h000080, 1'b0, "lru2/hitA");
      access(24'h000880, 1'b0, "lru2/hitB");
      access(24'h000080, 1'b0, "lru2/hitA2");
      access(24'h002080, 1'b1, "lru2/B4");
      access(24'h000080, 1'b0, "lru2/A_kept");
      access(24'h000880, 1'b0, "lru2/B_kept");
      access(24'h001880, 1'b0, "lru2/B3_kept");
      access(24'h001080, 1'b1, "lru2/B2_evicted");

      // Invalidate during a fill: word delivered, line left invalid.
      bus.fetch      = 1'b1;
      bus.fetch_addr = 24'h0000A8;
      step();
      chk("invfill/code_rd", 64'(bus.code_rd), 64'd1);
      fill_line(22'h2A, "invfill", 3);
      access(24'h0000A8, 1'b1, "invfill/refetch");

      // Invalidate in the lookup cycle hides a valid line.
      bus.fetch      = 1'b1;
      bus.fetch_addr = 24'h0000A8;
      bus.invalidate = 1'b1;
      step();
      bus.invalidate = 1'b0;
      chk("invidle/code_rd", 64'(bus.code_rd), 64'd1);
      fill_line(22'h2A, "invidle", -1);
      access(24'h0000A8, 1'b0, "invidle/hit_after");

      // Reset during a fill at word 3.
      bus.fetch      = 1'b1;
      bus.fetch_addr = 24'h0000C0;
      step();
      chk("rstfill/code_rd", 64'(bus.code_rd), 64'd1);
      for (int k = 0; k < 3; k++) begin
         bus.code_valid = 1'b1;
         bus.code_data  = 32'hA500_0030 + 32'(k);
         step();
         bus.fetch = 1'b0;
      end
      bus.code_valid = 1'b0;
      chk("rstfill/code_addr_w3", 64'(bus.code_addr), 64'h33);
      rstn = 1'b0;
      #1;
      chk("rstfill/code_rd_async", 64'(bus.code_rd), 64'd0);
      chk("rstfill/busy_async", 64'(bus.busy), 64'd0);
      chk("rstfill/code_addr_async", 64'(bus.code_addr), 64'd0);
      step();
      rstn = 1'b1;
      step();
      access(24'h0000C0, 1'b1, "rstfill/miss_after");

      // code_valid in IDLE has no effect.
      bus.code_valid = 1'b1;
      bus.code_data  = 32'hDEAD_BEEF;
      step();
      bus.code_valid = 1'b0;
      chk("stray/busy", 64'(bus.busy), 64'd0);
      chk("stray/code_rd", 64'(bus.code_rd), 64'd0);
      chk("stray/ready", 64'(bus.inst_ready), 64'd0);
      access(24'h0000C4, 1'b0, "stray/hit_after");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
